// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_unit_pkg;

  localparam logic [4:0]  STOP_OPCODE = 5'b11111;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam int          FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic is_stop(input logic [31:0] word);
    return word[31:27] == STOP_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus: one-cycle request pulse, response strobe with data.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_valid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_unit_queue.sv
// Small {pc,inst} FIFO between the memory response and the operand-fetch stage.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

  fetch_entry_t  mem_q [FIFO_DEPTH];
  fetch_entry_t  mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // a full queue only accepts a write when the head leaves in the same cycle
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: one outstanding read, 2-deep output queue,
// branch redirect with stale-response drop, and halt on the stop opcode.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                branch_taken,
  input  logic [31:0]         branch_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         inst,
  output logic [31:0]         pc,
  output logic                halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         outst_q, outst_d;
  logic         drop_q, drop_d;

  logic         redirect, rsp, keep, stop_push, pop, room, issue;
  logic         q_full, q_empty;
  fetch_entry_t q_head, q_wr;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    redirect  = branch_taken & (state_q != HALTED);
    rsp       = imem.imem_valid & outst_q;
    // responses are kept only while fetching and only if not stale
    keep      = rsp & ~drop_q & ~redirect & (state_q == FETCH);
    stop_push = keep & is_stop(imem.imem_rdata);
    out_valid = ~q_empty & (state_q != HALTED);
    pop       = out_valid & out_ready;
    // occupancy after this cycle's push/pop must leave a slot for the new request
    room      = q_full ? (pop & ~keep) : (q_empty | ~keep | pop);
    issue     = rst_n & (state_q == FETCH) & ~redirect & ~stop_push &
                (~outst_q | (rsp & ~drop_q)) & room;

    q_wr.pc   = req_pc_q;
    q_wr.inst = imem.imem_rdata;

    if (issue) begin
      outst_d  = 1'b1;
      req_pc_d = fetch_pc_q;
    end else if (rsp) begin
      outst_d = 1'b0;
    end

    if (rsp)                      drop_d = 1'b0;
    else if (redirect && outst_q) drop_d = 1'b1;

    if (redirect)   fetch_pc_d = branch_pc;
    else if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;

    case (state_q)
      FETCH:     if (stop_push) state_d = HALT_PEND;
      // delivering the stop word wins over a same-cycle redirect
      HALT_PEND: if (pop && is_stop(q_head.inst)) state_d = HALTED;
                 else if (redirect)               state_d = FETCH;
      HALTED:    state_d = HALTED;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (keep),
    .pop     (pop),
    .flush   (redirect),
    .wr_data (q_wr),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign imem.imem_req  = issue;
  assign imem.imem_addr = issue ? fetch_pc_q : '0;
  assign inst           = q_head.inst;
  assign pc             = q_head.pc;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, wrap, halt, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, halted;
  logic [31:0] inst, pc;

  int tests = 0;
  int fails = 0;

  // memory model state
  int          mem_lat = 1;
  bit          mem_en = 1'b1;
  logic [31:0] stop_addr = 32'h0000_0001;
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        man_valid = 1'b0;
  logic [31:0] man_rdata = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  logic [31:0] req_log [$];
  logic [31:0] del_pc [$];
  logic [31:0] del_inst [$];

  fetch_unit_if imem_if ();

  assign imem_if.imem_valid = mem_en ? m_valid : man_valid;
  assign imem_if.imem_rdata = mem_en ? m_rdata : man_rdata;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_if),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .inst         (inst),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == stop_addr) ? 32'hF800_0000 : {8'h3C, a[23:0]};
  endfunction

  // fixed-latency memory: request seen in cycle t answers in cycle t+mem_lat
  initial begin : mem_model
    bit          req_now, rst_now;
    logic [31:0] addr_now;
    forever begin
      @(negedge clk);
      req_now  = (imem_if.imem_req === 1'b1);
      addr_now = imem_if.imem_addr;
      rst_now  = (rst_n === 1'b1);
      @(posedge clk); #1;
      m_valid = 1'b0;
      if (!rst_now) pend = 1'b0;
      else if (mem_en) begin
        if (req_now) begin pend = 1'b1; paddr = addr_now; cnt = mem_lat; end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin m_valid = 1'b1; m_rdata = mem_word(paddr); pend = 1'b0; end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_if.imem_req === 1'b1) req_log.push_back(imem_if.imem_addr);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          del_pc.push_back(pc);
          del_inst.push_back(inst);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0; branch_taken = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    tests++; if (imem_if.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", imem_if.imem_req); end
    tests++; if (imem_if.imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_if.imem_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL rst_inst got %h exp 0", inst); end
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", pc); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got %b exp 0", halted); end
    cyc();
  endtask

  task automatic test_stream();
    int rb, db;
    rst_n = 1'b1; out_ready = 1'b1;
    rb = req_log.size(); db = del_pc.size();
    smp();
    tests++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin
      fails++; $display("FAIL stream_first_req got %b/%h exp 1/00000000", imem_if.imem_req, imem_if.imem_addr); end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin cyc(); smp(); end
      tests++; if (out_valid !== (k >= 2)) begin fails++; $display("FAIL stream_valid k=%0d got %b exp %b", k, out_valid, (k >= 2)); end
    end
    cyc();
    tests++; if (req_log.size() - rb != 12 || del_pc.size() - db != 10) begin
      fails++; $display("FAIL stream_counts got req %0d del %0d exp 12/10", req_log.size() - rb, del_pc.size() - db); end
    else begin
      for (int i = 0; i < 12; i++) begin
        tests++; if (req_log[rb+i] !== 32'(4*i)) begin fails++; $display("FAIL stream_addr[%0d] got %h exp %h", i, req_log[rb+i], 32'(4*i)); end
      end
      for (int i = 0; i < 10; i++) begin
        tests++; if (del_pc[db+i] !== 32'(4*i) || del_inst[db+i] !== mem_word(32'(4*i))) begin
          fails++; $display("FAIL stream_del[%0d] got %h/%h exp %h/%h", i, del_pc[db+i], del_inst[db+i], 32'(4*i), mem_word(32'(4*i))); end
      end
    end
  endtask

  task automatic test_backpressure();
    int rb, db;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      smp();
      tests++; if (imem_if.imem_req !== 1'b0) begin fails++; $display("FAIL bp_req i=%0d got %b exp 0", i, imem_if.imem_req); end
      tests++; if (out_valid !== 1'b1 || pc !== 32'h28 || inst !== mem_word(32'h28)) begin
        fails++; $display("FAIL bp_hold i=%0d got %b/%h/%h exp 1/00000028/%h", i, out_valid, pc, inst, mem_word(32'h28)); end
    end
    cyc();
    out_ready = 1'b1;
    rb = req_log.size(); db = del_pc.size();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      smp();
    end
    cyc();
    tests++; if (del_pc.size() - db < 3 || req_log.size() - rb < 2) begin
      fails++; $display("FAIL bp_release_counts got del %0d req %0d exp >=3/>=2", del_pc.size() - db, req_log.size() - rb); end
    else begin
      tests++; if (del_pc[db] !== 32'h28 || del_pc[db+1] !== 32'h2C || del_pc[db+2] !== 32'h30) begin
        fails++; $display("FAIL bp_release_order got %h %h %h exp 28 2c 30", del_pc[db], del_pc[db+1], del_pc[db+2]); end
      tests++; if (req_log[rb] !== 32'h30 || req_log[rb+1] !== 32'h34) begin
        fails++; $display("FAIL bp_release_req got %h %h exp 30 34", req_log[rb], req_log[rb+1]); end
    end
  endtask

  task automatic test_redirect();
    bit found;
    found = 1'b0;
    smp();
    mem_lat = 4;
    do_reset();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (imem_if.imem_req === 1'b1 && imem_if.imem_addr === 32'h10) begin found = 1'b1; break; end
      cyc();
    end
    tests++; if (!found) begin fails++; $display("FAIL redir_find_req got none exp addr 00000010"); end
    cyc();
    branch_taken = 1'b1; branch_pc = 32'h100;
    smp();
    tests++; if (imem_if.imem_req !== 1'b0) begin fails++; $display("FAIL redir_no_issue got %b exp 0", imem_if.imem_req); end
    cyc();
    branch_taken = 1'b0;
    smp();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_flush got %b exp 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); smp(); end
      tests++; if (imem_if.imem_req !== 1'b0) begin fails++; $display("FAIL redir_wait i=%0d got %b exp 0", i, imem_if.imem_req); end
    end
    cyc(); smp();
    tests++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h100) begin
      fails++; $display("FAIL redir_target_req got %b/%h exp 1/00000100", imem_if.imem_req, imem_if.imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(); smp();
      if (out_valid === 1'b1) begin found = 1'b1; break; end
    end
    tests++; if (!found || pc !== 32'h100 || inst !== mem_word(32'h100)) begin
      fails++; $display("FAIL redir_first_del got %b/%h/%h exp 1/00000100/%h", found, pc, inst, mem_word(32'h100)); end
  endtask

  task automatic test_wrap();
    int rb, db;
    mem_lat = 1;
    cyc();
    branch_taken = 1'b1; branch_pc = 32'hFFFF_FFF8;
    cyc();
    branch_taken = 1'b0;
    rb = req_log.size(); db = del_pc.size();
    for (int i = 0; i < 14; i++) cyc();
    tests++; if (req_log.size() - rb < 4 || del_pc.size() - db < 3) begin
      fails++; $display("FAIL wrap_counts got req %0d del %0d exp >=4/>=3", req_log.size() - rb, del_pc.size() - db); end
    else begin
      tests++; if (req_log[rb] !== 32'hFFFF_FFF8 || req_log[rb+1] !== 32'hFFFF_FFFC ||
                   req_log[rb+2] !== 32'h0 || req_log[rb+3] !== 32'h4) begin
        fails++; $display("FAIL wrap_addr got %h %h %h %h exp fffffff8 fffffffc 0 4",
                          req_log[rb], req_log[rb+1], req_log[rb+2], req_log[rb+3]); end
      tests++; if (del_pc[db+1] !== 32'hFFFF_FFFC || del_pc[db+2] !== 32'h0 || del_inst[db+2] !== mem_word(32'h0)) begin
        fails++; $display("FAIL wrap_del got %h %h/%h exp fffffffc 0/%h", del_pc[db+1], del_pc[db+2], del_inst[db+2], mem_word(32'h0)); end
    end
  endtask

  task automatic test_halt();
    int rb;
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
    smp();
    stop_addr = 32'h8;
    do_reset();
    rst_n = 1'b1; out_ready = 1'b1;
    rb = req_log.size();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      smp();
      if (k < 5) begin
        tests++; if (out_valid !== (k >= 2) || halted !== 1'b0 || (k >= 2 && pc !== exp_pc[k])) begin
          fails++; $display("FAIL halt_seq k=%0d got v%b h%b pc %h exp v%b h0 pc %h", k, out_valid, halted, pc, (k >= 2), exp_pc[k]); end
      end else begin
        tests++; if (halted !== 1'b1 || out_valid !== 1'b0) begin
          fails++; $display("FAIL halt_enter got h%b v%b exp h1 v0", halted, out_valid); end
      end
    end
    tests++; if (del_inst.size() == 0 || del_inst[del_inst.size()-1] !== 32'hF800_0000) begin
      fails++; $display("FAIL halt_stop_word_delivered got size %0d exp last f8000000", del_inst.size()); end
    cyc();
    branch_taken = 1'b1; branch_pc = 32'h200;
    cyc();
    branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      tests++; if (halted !== 1'b1 || imem_if.imem_req !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL halt_hold i=%0d got h%b r%b v%b exp h1 r0 v0", i, halted, imem_if.imem_req, out_valid); end
      cyc();
    end
    tests++; if (req_log.size() - rb != 3) begin
      fails++; $display("FAIL halt_req_count got %0d exp 3", req_log.size() - rb); end
    else begin
      tests++; if (req_log[rb] !== 32'h0 || req_log[rb+1] !== 32'h4 || req_log[rb+2] !== 32'h8) begin
        fails++; $display("FAIL halt_req_addr got %h %h %h exp 0 4 8", req_log[rb], req_log[rb+1], req_log[rb+2]); end
    end
  endtask

  task automatic test_reset_mid();
    smp();
    mem_en = 1'b0; stop_addr = 32'h1;
    do_reset();
    rst_n = 1'b1;
    smp();
    tests++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin
      fails++; $display("FAIL rmid_first got %b/%h exp 1/0", imem_if.imem_req, imem_if.imem_addr); end
    cyc();
    rst_n = 1'b0;
    smp();
    tests++; if (imem_if.imem_req !== 1'b0) begin fails++; $display("FAIL rmid_in_reset got %b exp 0", imem_if.imem_req); end
    cyc();
    rst_n = 1'b1; man_valid = 1'b1; man_rdata = 32'h0BAD_F00D;
    smp();
    tests++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h0) begin
      fails++; $display("FAIL rmid_reissue got %b/%h exp 1/0", imem_if.imem_req, imem_if.imem_addr); end
    cyc();
    man_valid = 1'b0;
    smp();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_late_dropped got %b exp 0", out_valid); end
    cyc(); smp();
    tests++; if (out_valid !== 1'b0 || imem_if.imem_req !== 1'b0) begin
      fails++; $display("FAIL rmid_wait got v%b r%b exp v0 r0", out_valid, imem_if.imem_req); end
    cyc();
    man_valid = 1'b1; man_rdata = 32'h1234_5678;
    smp();
    tests++; if (out_valid !== 1'b0 || imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 32'h4) begin
      fails++; $display("FAIL rmid_resp_cycle got v%b r%b a%h exp v0 r1 a4", out_valid, imem_if.imem_req, imem_if.imem_addr); end
    cyc();
    man_valid = 1'b0;
    smp();
    tests++; if (out_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h1234_5678) begin
      fails++; $display("FAIL rmid_fresh got %b/%h/%h exp 1/0/12345678", out_valid, pc, inst); end
  endtask

  initial begin : main
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: imem_req  output  1  instruction memory read request, one-cycle pulse per request.
REQ-004 SHALL have port: imem_addr  output  32  byte address of the request, valid while imem_req=1.
REQ-005 SHALL have ports: imem_valid  input  1  response strobe; imem_rdata  input  32  returned instruction word.
REQ-006 SHALL have ports: branch_taken  input  1  redirect pulse; branch_pc  input  32  redirect target.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1  operand-fetch stage can accept.
REQ-008 SHALL have ports: inst  output  32; pc  output  32  (byte address of inst); halted  output  1.

Function
REQ-009 SHALL keep a fetch PC register; each issued request uses the current fetch PC, then the fetch PC advances by 4 (mod 2^32, wrap 0xFFFFFFFC->0x00000000).
REQ-010 SHALL allow at most one outstanding memory request; response latency is >=1 cycle, unbounded.
REQ-011 SHALL buffer returned instructions and their PCs in a 2-entry FIFO; inst/pc show the head entry, out_valid = FIFO non-empty.
REQ-012 SHALL pop the head when out_valid=1 and out_ready=1; inst/pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 SHALL issue a request only when (no outstanding request OR imem_valid this cycle) AND FIFO occupancy + outstanding after this cycle's push/pop is <2, guaranteeing no response is ever dropped for lack of space.
REQ-014 SHALL push a response in the same cycle imem_valid=1 (unless discarded per REQ-016); push and pop in the same cycle SHALL both occur with occupancy unchanged.
REQ-015 On branch_taken=1 the FIFO SHALL be flushed (out_valid=0 next cycle), fetch PC SHALL load branch_pc, and no request SHALL issue that cycle; redirect overrides push, pop and issue.
REQ-016 A response outstanding at, or arriving in, a redirect cycle SHALL be discarded via a drop flag; the first request to branch_pc issues the cycle after the dropped response returns (or the cycle after redirect if none outstanding).
REQ-017 SHALL implement states FETCH, HALT_PEND, HALTED: FETCH->HALT_PEND when a pushed word has imem_rdata[31:27]=5'b11111; HALT_PEND->HALTED when that word is popped; HALT_PEND->FETCH on branch_taken.
REQ-018 In HALT_PEND and HALTED no new requests SHALL issue; words returning after the stop word SHALL be discarded.
REQ-019 In HALTED, halted=1, out_valid=0, branch_taken ignored; only reset exits.
REQ-020 branch_taken and out_ready SHALL be independent; a redirect in the same cycle as a pop still counts the pop as delivered.

Reset
REQ-021 While rst_n=0 at a clock edge: fetch PC=0, FIFO empty, outstanding and drop flags clear, state=FETCH.
REQ-022 Outputs during/after reset edge: imem_req=0, imem_addr=0, out_valid=0, inst=0, pc=0, halted=0.
REQ-023 Reset mid-operation SHALL abandon any outstanding request; a late imem_valid in the first cycle after reset SHALL be discarded; first request (addr 0) issues the first cycle rst_n=1.

Structure
REQ-024 Shared package SHALL hold the state enum, STOP_OPCODE=5'b11111, RESET_PC=32'h0, PC_STEP=4, FIFO_DEPTH=2.
REQ-025 The 2-entry {pc,inst} FIFO SHALL be a sub-module named fetch_queue with push/pop/flush and full/empty flags.

Verification
REQ-026 Reset, 1-cycle memory, out_ready=1 -> requests to 0x0,0x4,0x8... ; pc out 0x0,0x4,0x8 in order, no gaps after pipeline fill.
REQ-027 out_ready=0 for 10 cycles, 1-cycle memory -> FIFO fills to 2, imem_req stays 0, inst/pc unchanged; release -> both words delivered in order.
REQ-028 Request to 0x10 outstanding, branch_taken with branch_pc=0x100, response 3 cycles later -> that word discarded, next imem_addr=0x100, next delivered pc=0x100.
REQ-029 Word 0xF8000000 returned at pc 0x8 -> no further requests; halted=1 cycle after pc=0x8 popped; later branch_taken no effect.
REQ-030 Fetch PC at 0xFFFFFFFC -> next imem_addr=0x00000000.
REQ-031 rst_n=0 with request outstanding, imem_valid in first post-reset cycle -> word discarded, imem_addr=0 issued, out_valid=0 until fresh response.
